// File: rtl/fetch_pc.sv
// Program-counter and instruction-fetch sequencer: one outstanding imem request,
// valid/ready delivery to decode, and redirect on resolved branches/jumps.
module fetch_pc #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve_valid,
  input  logic [31:0] pc_in,
  input  logic [31:0] branch_out,
  input  logic        jalr_op,
  output logic        redirect_taken,
  output logic        misaligned_err,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        kill_reg, kill_next;
  logic [31:0] addr_reg, addr_next;
  logic        inst_valid_reg, inst_valid_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] pc_out_reg, pc_out_next;
  logic        redirect_reg, misaligned_reg;

  logic [31:0] target;
  logic        redirect_req;
  logic        redirect;
  logic        misaligned;

  assign target       = jalr_op ? (branch_out & ~32'h1) : (pc_in + branch_out);
  assign redirect_req = resolve_valid && (jalr_op || (branch_out != 32'h4));
  assign redirect     = redirect_req && !target[1];
  assign misaligned   = redirect_req && target[1];

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    kill_next       = kill_reg;
    addr_next       = addr_reg;
    inst_valid_next = inst_valid_reg;
    inst_next       = inst_reg;
    pc_out_next     = pc_out_reg;

    case (state_reg)
      IDLE: begin
        pc_next    = redirect ? target : pc_reg;
        addr_next  = {pc_next[31:2], 2'b00};
        state_next = REQ;
      end

      REQ: begin
        // The address stays on the bus until granted; a redirect only marks it wrong-path.
        kill_next = kill_reg | redirect;
        if (imem_gnt) begin
          state_next = WAIT;
          if (redirect)
            pc_next = target;
          else if (!kill_reg)
            pc_next = pc_reg + 32'h4;
        end else if (redirect) begin
          pc_next = target;
        end
      end

      WAIT: begin
        if (redirect) begin
          pc_next = target;
          if (imem_rvalid) begin
            kill_next  = 1'b0;
            addr_next  = {target[31:2], 2'b00};
            state_next = REQ;
          end else begin
            kill_next = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_reg) begin
            kill_next  = 1'b0;
            addr_next  = {pc_reg[31:2], 2'b00};
            state_next = REQ;
          end else begin
            inst_next       = imem_rdata;
            pc_out_next     = addr_reg;
            inst_valid_next = 1'b1;
            state_next      = HOLD;
          end
        end
      end

      HOLD: begin
        // A coincident transfer has already completed; only the next fetch moves.
        if (redirect) begin
          pc_next         = target;
          inst_valid_next = 1'b0;
          addr_next       = {target[31:2], 2'b00};
          state_next      = REQ;
        end else if (inst_ready) begin
          inst_valid_next = 1'b0;
          addr_next       = {pc_reg[31:2], 2'b00};
          state_next      = REQ;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_ADDR;
      kill_reg       <= 1'b0;
      addr_reg       <= RESET_ADDR;
      inst_valid_reg <= 1'b0;
      inst_reg       <= 32'h0;
      pc_out_reg     <= 32'h0;
      redirect_reg   <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      kill_reg       <= kill_next;
      addr_reg       <= addr_next;
      inst_valid_reg <= inst_valid_next;
      inst_reg       <= inst_next;
      pc_out_reg     <= pc_out_next;
      redirect_reg   <= redirect;
      misaligned_reg <= misaligned;
    end
  end

  assign imem_req       = (state_reg == REQ);
  assign imem_addr      = addr_reg;
  assign inst_valid     = inst_valid_reg;
  assign inst_out       = inst_reg;
  assign pc_out         = pc_out_reg;
  assign redirect_taken = redirect_reg;
  assign misaligned_err = misaligned_reg;

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: memory responder, expected-fetch-stream model, directed redirect scenarios.
module tb_fetch_pc;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        resolve_valid;
  logic [31:0] pc_in;
  logic [31:0] branch_out;
  logic        jalr_op;
  logic        redirect_taken;
  logic        misaligned_err;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  logic        gnt_en;
  int          rsp_delay;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] log_q[$];

  // model state (monitor-owned)
  logic [31:0] exp_pc;
  logic        exp_redir, exp_mis, after_rst, outstanding, prev_hold, fire;
  logic [31:0] prev_pc, prev_inst, fire_addr;

  fetch_pc #(.RESET_ADDR(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .resolve_valid(resolve_valid), .pc_in(pc_in), .branch_out(branch_out), .jalr_op(jalr_op),
    .redirect_taken(redirect_taken), .misaligned_err(misaligned_err),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  assign imem_gnt = imem_req && gnt_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: responds rsp_delay cycles after the cycle following the grant.
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] rsp_addr;
    pend = 1'b0; cnt = 0; rsp_addr = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (fire) begin
          pend = 1'b1; cnt = rsp_delay; rsp_addr = fire_addr;
        end
        if (pend) begin
          if (cnt == 0) begin
            imem_rvalid = 1'b1; imem_rdata = mem_word(rsp_addr); pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Model: the next delivered instruction must be at exp_pc; deliveries advance it by 4,
  // an aligned taken resolution replaces it with the target.
  initial begin
    logic [31:0] tgt;
    logic        nr, nm, redir_now;
    exp_pc = RST_PC; exp_redir = 1'b0; exp_mis = 1'b0; after_rst = 1'b0;
    outstanding = 1'b0; prev_hold = 1'b0; fire = 1'b0; fire_addr = 32'h0;
    prev_pc = 32'h0; prev_inst = 32'h0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        exp_pc = RST_PC; exp_redir = 1'b0; exp_mis = 1'b0; outstanding = 1'b0;
        after_rst = 1'b1; prev_hold = 1'b0; fire = 1'b0;
      end else begin
        if (after_rst) begin
          check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
          check("rst_imem_req", {31'h0, imem_req}, 32'h0);
          check("rst_imem_addr", imem_addr, RST_PC);
          check("rst_pc_out", pc_out, 32'h0);
          check("rst_inst_out", inst_out, 32'h0);
          after_rst = 1'b0;
        end
        check("redirect_taken", {31'h0, redirect_taken}, {31'h0, exp_redir});
        check("misaligned_err", {31'h0, misaligned_err}, {31'h0, exp_mis});
        if (imem_req) check("req_while_outstanding", {31'h0, outstanding}, 32'h0);
        if (prev_hold) begin
          check("hold_valid", {31'h0, inst_valid}, 32'h1);
          check("hold_pc_out", pc_out, prev_pc);
          check("hold_inst_out", inst_out, prev_inst);
        end
        if (inst_valid && inst_ready) begin
          check("deliver_pc_out", pc_out, exp_pc);
          check("deliver_inst_out", inst_out, mem_word(pc_out));
          log_q.push_back(pc_out);
          exp_pc = exp_pc + 32'h4;
        end
        nr = 1'b0; nm = 1'b0; redir_now = 1'b0;
        if (resolve_valid && (jalr_op || branch_out != 32'h4)) begin
          tgt = jalr_op ? {branch_out[31:1], 1'b0} : pc_in + branch_out;
          if (tgt[1]) nm = 1'b1;
          else begin exp_pc = tgt; nr = 1'b1; redir_now = 1'b1; end
        end
        exp_redir = nr; exp_mis = nm;
        if (imem_rvalid) outstanding = 1'b0;
        if (imem_req && imem_gnt) outstanding = 1'b1;
        fire = imem_req && imem_gnt;
        fire_addr = imem_addr;
        prev_hold = inst_valid && !inst_ready && !redir_now;
        prev_pc = pc_out; prev_inst = inst_out;
      end
    end
  end

  // kind: 0 inst_valid, 1 waiting with no response yet, 2 response present, 3 request up
  task automatic wait_cond(input int kind, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      case (kind)
        0: hit = inst_valid;
        1: hit = outstanding && !imem_rvalid && !imem_req;
        2: hit = imem_rvalid;
        default: hit = imem_req;
      endcase
    end
    if (!hit) check({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic expect_next(input logic [31:0] exp, input string name);
    int n;
    bit got;
    n = log_q.size();
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (log_q.size() > n);
    end
    if (got) check(name, log_q[n], exp);
    else check({name, "_timeout"}, 32'h0, exp);
  endtask

  task automatic do_resolve(input logic [31:0] p, input logic [31:0] b, input logic j);
    resolve_valid = 1'b1; pc_in = p; branch_out = b; jalr_op = j;
    @(negedge clk);
    resolve_valid = 1'b0; pc_in = 32'h0; branch_out = 32'h0; jalr_op = 1'b0;
  endtask

  initial begin
    logic [31:0] p, e;
    bit hit;
    rst = 1'b1; resolve_valid = 1'b0; pc_in = 32'h0; branch_out = 32'h0; jalr_op = 1'b0;
    inst_ready = 1'b1; gnt_en = 1'b1; rsp_delay = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    expect_next(32'h100, "seq0");
    expect_next(32'h104, "seq1");
    expect_next(32'h108, "seq2");

    rsp_delay = 2;
    wait_cond(1, "rst_wait_state");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rsp_delay = 0;
    expect_next(32'h100, "rst_restart");

    inst_ready = 1'b0;
    wait_cond(0, "stall_hold");
    p = pc_out;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'h0, inst_valid}, 32'h1);
      check("stall_req", {31'h0, imem_req}, 32'h0);
      check("stall_pc_out", pc_out, p);
      check("stall_inst_out", inst_out, mem_word(p));
      @(negedge clk);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    check("zero_bubble_req", {31'h0, imem_req}, 32'h1);
    check("after_stall_addr", imem_addr, p + 32'h4);

    rsp_delay = 1;
    wait_cond(1, "redir_wait_state");
    do_resolve(32'h200, 32'hFFFF_FFF0, 1'b0);
    check("redir_wait_pulse", {31'h0, redirect_taken}, 32'h1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      hit = imem_req;
      if (!hit) begin
        check("killed_no_valid", {31'h0, inst_valid}, 32'h0);
        @(negedge clk);
      end
    end
    check("redir_wait_addr", imem_addr, 32'h1F0);
    rsp_delay = 0;
    expect_next(32'h1F0, "redir_wait_deliver");

    do_resolve(32'h1234, 32'h0000_3001, 1'b1);
    check("jalr_pulse", {31'h0, redirect_taken}, 32'h1);
    expect_next(32'h3000, "jalr_target");

    do_resolve(32'h0, 32'h0000_3002, 1'b1);
    check("misaligned_pulse", {31'h0, misaligned_err}, 32'h1);
    check("misaligned_no_redir", {31'h0, redirect_taken}, 32'h0);
    e = log_q[log_q.size() - 1] + 32'h4;
    expect_next(e, "misaligned_sequential");

    do_resolve(32'h500, 32'h4, 1'b0);
    check("not_taken_no_redir", {31'h0, redirect_taken}, 32'h0);
    e = log_q[log_q.size() - 1] + 32'h4;
    expect_next(e, "not_taken_sequential");

    wait_cond(2, "rvalid_coincident");
    do_resolve(32'h700, 32'h100, 1'b0);
    expect_next(32'h800, "redir_rvalid");

    wait_cond(3, "grant_coincident");
    do_resolve(32'h300, 32'h100, 1'b0);
    expect_next(32'h400, "redir_grant");

    gnt_en = 1'b0;
    wait_cond(3, "req_no_grant");
    do_resolve(32'h400, 32'h80, 1'b0);
    @(negedge clk);
    gnt_en = 1'b1;
    expect_next(32'h480, "redir_req_stalled");

    inst_ready = 1'b0;
    wait_cond(0, "hold_redirect");
    do_resolve(32'h900, 32'h20, 1'b0);
    check("hold_redirect_drop", {31'h0, inst_valid}, 32'h0);
    inst_ready = 1'b1;
    expect_next(32'h920, "redir_hold");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
